// File: rtl/regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu_pipe
// Purpose  : Two-stage register-file / ALU datapath. Stage 1 reads operands
//            (with EX-result bypass), stage 2 executes, writes back, updates
//            flags and registers the result. One debug read port.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       opCode,
  input  logic [AW-1:0]    a_select,
  input  logic [AW-1:0]    b_select,
  input  logic [AW-1:0]    dest_select,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] immediate,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  input  logic [AW-1:0]    dbg_select,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [7:0] c_OP_NOP   = 8'h00;
  localparam logic [7:0] c_OP_AND   = 8'h01;
  localparam logic [7:0] c_OP_OR    = 8'h02;
  localparam logic [7:0] c_OP_XOR   = 8'h03;
  localparam logic [7:0] c_OP_ADDCU = 8'h04;
  localparam logic [7:0] c_OP_ADD   = 8'h05;
  localparam logic [7:0] c_OP_ADDU  = 8'h06;
  localparam logic [7:0] c_OP_ADDC  = 8'h07;
  localparam logic [7:0] c_OP_CMPU  = 8'h08;
  localparam logic [7:0] c_OP_SUB   = 8'h09;
  localparam logic [7:0] c_OP_CMP   = 8'h0B;
  localparam logic [7:0] c_OP_MOV   = 8'h0D;
  localparam logic [7:0] c_OP_NOT   = 8'h0F;
  localparam logic [7:0] c_OP_LSH   = 8'h84;
  localparam logic [7:0] c_OP_RSH   = 8'h85;
  localparam logic [7:0] c_OP_ALSH  = 8'h86;
  localparam logic [7:0] c_OP_ARSH  = 8'h87;

  // Flag bit positions within {Z, C, F, L, N}
  localparam int c_FZ = 4;
  localparam int c_FC = 3;
  localparam int c_FF = 2;
  localparam int c_FL = 1;
  localparam int c_FN = 0;

  localparam int                c_MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0]  c_WIDTH_V = WIDTH'(WIDTH);

  // Architectural state
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [4:0]       r_flags;

  // EX stage register
  logic             r_ex_valid;
  logic [7:0]       r_ex_op;
  logic [AW-1:0]    r_ex_dest;
  logic [WIDTH-1:0] r_ex_a;
  logic [WIDTH-1:0] r_ex_b;

  // Output register
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;

  // EX combinational signals
  logic [WIDTH-1:0] w_res;
  logic             w_wr;
  logic             w_upd_all;
  logic             w_upd_zn;
  logic             w_c;
  logic             w_f;
  logic             w_l;
  logic [4:0]       w_flags_nxt;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_slt;
  logic             w_ult;
  logic             w_big;
  logic [SW-1:0]    w_shamt;
  logic             w_fwd_en;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;

  // Shared adder / subtractor and comparison terms
  assign w_cin     = ((r_ex_op == c_OP_ADDC) || (r_ex_op == c_OP_ADDCU)) ? r_flags[c_FC] : 1'b0;
  assign w_sum     = {1'b0, r_ex_a} + {1'b0, r_ex_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff    = {1'b0, r_ex_a} - {1'b0, r_ex_b};
  assign w_add_ovf = (r_ex_a[c_MSB] == r_ex_b[c_MSB]) && (w_sum[c_MSB] != r_ex_a[c_MSB]);
  assign w_sub_ovf = (r_ex_a[c_MSB] != r_ex_b[c_MSB]) && (w_diff[c_MSB] != r_ex_a[c_MSB]);
  assign w_slt     = $signed(r_ex_a) < $signed(r_ex_b);
  assign w_ult     = r_ex_a < r_ex_b;
  // Amounts of WIDTH or more saturate; otherwise the low bits are the amount
  assign w_big     = r_ex_b >= c_WIDTH_V;
  assign w_shamt   = r_ex_b[SW-1:0];

  // ALU: result, write enable and flag contributions of the EX instruction
  always_comb begin
    w_res     = '0;
    w_wr      = 1'b0;
    w_upd_all = 1'b0;
    w_upd_zn  = 1'b0;
    w_c       = 1'b0;
    w_f       = 1'b0;
    w_l       = 1'b0;
    case (r_ex_op)
      c_OP_AND: begin w_res = r_ex_a & r_ex_b; w_wr = 1'b1; w_upd_zn = 1'b1; end
      c_OP_OR:  begin w_res = r_ex_a | r_ex_b; w_wr = 1'b1; w_upd_zn = 1'b1; end
      c_OP_XOR: begin w_res = r_ex_a ^ r_ex_b; w_wr = 1'b1; w_upd_zn = 1'b1; end
      c_OP_MOV: begin w_res = r_ex_b;          w_wr = 1'b1; w_upd_zn = 1'b1; end
      c_OP_NOT: begin w_res = ~r_ex_a;         w_wr = 1'b1; w_upd_zn = 1'b1; end
      c_OP_ADD, c_OP_ADDC: begin
        w_res = w_sum[WIDTH-1:0]; w_wr = 1'b1; w_upd_all = 1'b1;
        w_c = w_sum[WIDTH]; w_f = w_add_ovf; w_l = w_slt;
      end
      c_OP_ADDU, c_OP_ADDCU: begin
        w_res = w_sum[WIDTH-1:0]; w_wr = 1'b1; w_upd_all = 1'b1;
        w_c = w_sum[WIDTH]; w_f = w_add_ovf; w_l = w_ult;
      end
      c_OP_SUB: begin
        w_res = w_diff[WIDTH-1:0]; w_wr = 1'b1; w_upd_all = 1'b1;
        w_c = w_diff[WIDTH]; w_f = w_sub_ovf; w_l = w_slt;
      end
      // Compares report the difference but never write the file
      c_OP_CMP: begin
        w_res = w_diff[WIDTH-1:0]; w_upd_all = 1'b1;
        w_c = w_diff[WIDTH]; w_f = w_sub_ovf; w_l = w_slt;
      end
      c_OP_CMPU: begin
        w_res = w_diff[WIDTH-1:0]; w_upd_all = 1'b1;
        w_c = w_diff[WIDTH]; w_f = w_sub_ovf; w_l = w_ult;
      end
      c_OP_LSH, c_OP_ALSH: begin
        w_res = w_big ? '0 : (r_ex_a << w_shamt); w_wr = 1'b1; w_upd_zn = 1'b1;
      end
      c_OP_RSH: begin
        w_res = w_big ? '0 : (r_ex_a >> w_shamt); w_wr = 1'b1; w_upd_zn = 1'b1;
      end
      c_OP_ARSH: begin
        w_res = w_big ? {WIDTH{r_ex_a[c_MSB]}} : WIDTH'($signed(r_ex_a) >>> w_shamt);
        w_wr = 1'b1; w_upd_zn = 1'b1;
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // Next flag value: full update for arithmetic, Z/N only for logic/shift/move
  always_comb begin
    w_flags_nxt = r_flags;
    if (w_upd_all) begin
      w_flags_nxt = {(w_res == '0), w_c, w_f, w_l, w_res[c_MSB]};
    end else if (w_upd_zn) begin
      w_flags_nxt[c_FZ] = (w_res == '0);
      w_flags_nxt[c_FN] = w_res[c_MSB];
    end
  end

  // Operand read with bypass from the EX instruction's result
  assign w_fwd_en = r_ex_valid && w_wr;
  assign w_op_a   = (w_fwd_en && (r_ex_dest == a_select)) ? w_res : r_regs[a_select];
  assign w_op_b   = use_imm ? immediate :
                    ((w_fwd_en && (r_ex_dest == b_select)) ? w_res : r_regs[b_select]);

  // Stage 1: capture instruction and operands, or a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= c_OP_NOP;
      r_ex_dest  <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
    end else begin
      r_ex_valid <= in_valid;
      r_ex_op    <= opCode;
      r_ex_dest  <= dest_select;
      r_ex_a     <= w_op_a;
      r_ex_b     <= w_op_b;
    end
  end

  // Stage 2: write-back to the register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_ex_valid && w_wr) begin
      r_regs[r_ex_dest] <= w_res;
    end
  end

  // Stage 2: flags, result and completion strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_out_valid <= r_ex_valid && (r_ex_op != c_OP_NOP);
      if (r_ex_valid) begin
        r_flags  <= w_flags_nxt;
        r_result <= w_res;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign dbg_data  = r_regs[dbg_select];

endmodule
`default_nettype wire
